// File: rtl/count_display_pkg.sv
// Shared glyph codes, digit index type and output polarity helper for the
// multiplexed seven-segment count display.
package count_display_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_U     = 7'h3E;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef logic [1:0] digit_idx_t;

  typedef enum logic [1:0] {
    GLYPH_NUM,
    GLYPH_BLANK,
    GLYPH_U,
    GLYPH_D
  } glyph_t;

  typedef struct packed {
    logic [3:0] an;
    logic       dp;
    logic [6:0] seg;
  } disp_out_t;

  // Active-high bundle in, pin-level bundle out.
  function automatic disp_out_t apply_pol(input disp_out_t v, input bit active_low);
    return active_low ? disp_out_t'(~v) : v;
  endfunction

endpackage

// File: rtl/count_display_seg7_decode.sv
// Combinational glyph decoder: decimal digit or fixed glyph to gfedcba pattern.
module seg7_decode
  import count_display_pkg::*;
(
  input  logic [3:0] code,
  input  glyph_t     glyph,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (glyph)
      GLYPH_NUM: begin
        case (code)
          4'd0:    seg = SEG_0;
          4'd1:    seg = SEG_1;
          4'd2:    seg = SEG_2;
          4'd3:    seg = SEG_3;
          4'd4:    seg = SEG_4;
          4'd5:    seg = SEG_5;
          4'd6:    seg = SEG_6;
          4'd7:    seg = SEG_7;
          4'd8:    seg = SEG_8;
          4'd9:    seg = SEG_9;
          default: seg = SEG_BLANK;
        endcase
      end
      GLYPH_U:     seg = SEG_U;
      GLYPH_D:     seg = SEG_D;
      default:     seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/count_display.sv
// Four-digit multiplexed display of the up/down counter value and direction,
// with wrap detection, wrap pulse and a timed decimal-point indicator.
module count_display
  import count_display_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int WRAP_HOLD    = 25000000,
  parameter bit COMMON_ANODE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] count_in,
  input  logic       mode_in,
  input  logic       blank_lz,
  output logic [6:0] seg_out,
  output logic       dp_out,
  output logic [3:0] an_out,
  output logic       wrap_pulse
);

  localparam int DIV_W  = $clog2(REFRESH_DIV);
  localparam int HOLD_W = $clog2(WRAP_HOLD + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(WRAP_HOLD);
  localparam disp_out_t OUT_OFF = apply_pol(disp_out_t'('0), COMMON_ANODE);

  logic [3:0]        cnt_s;
  logic              mode_s;
  logic              sample_valid;
  logic              wrap_d;
  logic [HOLD_W-1:0] hold;
  logic [DIV_W-1:0]  div;
  digit_idx_t        idx;
  logic [3:0]        disp_val;
  logic              disp_mode;
  disp_out_t         out_r;

  logic [3:0] tens, ones, code;
  glyph_t     glyph;
  logic [6:0] pat;
  disp_out_t  out_nxt;

  // Wrap is judged against the incoming sample so wrap_d aligns with the
  // cnt_s update and the pulse lands one clk later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_s        <= '0;
      mode_s       <= 1'b1;
      sample_valid <= 1'b0;
      wrap_d       <= 1'b0;
      wrap_pulse   <= 1'b0;
      hold         <= '0;
    end else begin
      cnt_s        <= count_in;
      mode_s       <= mode_in;
      sample_valid <= 1'b1;
      wrap_d       <= sample_valid &&
                      ((cnt_s == 4'd15 && count_in == 4'd0  &&  mode_in) ||
                       (cnt_s == 4'd0  && count_in == 4'd15 && !mode_in));
      wrap_pulse   <= wrap_d;
      if (wrap_d)            hold <= HOLD_INIT;
      else if (hold != '0)   hold <= hold - 1'b1;
    end
  end

  // Display value is only refreshed at the 3->0 boundary so a scan never tears.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div       <= '0;
      idx       <= '0;
      disp_val  <= '0;
      disp_mode <= 1'b1;
    end else if (div == DIV_LAST) begin
      div <= '0;
      idx <= idx + 1'b1;
      if (idx == 2'd3) begin
        disp_val  <= cnt_s;
        disp_mode <= mode_s;
      end
    end else begin
      div <= div + 1'b1;
    end
  end

  assign tens = (disp_val >= 4'd10) ? 4'd1 : 4'd0;
  assign ones = (disp_val >= 4'd10) ? disp_val - 4'd10 : disp_val;

  always_comb begin
    code  = 4'd0;
    glyph = GLYPH_BLANK;
    case (idx)
      2'd0: begin code = ones; glyph = GLYPH_NUM; end
      2'd1: begin
        code  = tens;
        glyph = (blank_lz && tens == 4'd0) ? GLYPH_BLANK : GLYPH_NUM;
      end
      2'd2:    glyph = GLYPH_BLANK;
      default: glyph = disp_mode ? GLYPH_U : GLYPH_D;
    endcase
  end

  seg7_decode u_dec (
    .code  (code),
    .glyph (glyph),
    .seg   (pat)
  );

  always_comb begin
    out_nxt.an  = 4'(1) << idx;
    out_nxt.dp  = (hold != '0) && (idx == 2'd0);
    out_nxt.seg = pat;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) out_r <= OUT_OFF;
    else        out_r <= apply_pol(out_nxt, COMMON_ANODE);
  end

  assign an_out  = out_r.an;
  assign dp_out  = out_r.dp;
  assign seg_out = out_r.seg;

endmodule

// File: tb/tb_count_display.sv
// Scoreboard bench for count_display: stimulus queues expected digit frames,
// wrap pulse times and decimal-point run lengths; monitors pop and compare.
module tb_count_display;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] count_in = 4'd0;
  logic       mode_in = 1'b1;
  logic       blank_lz = 1'b0;
  logic [6:0] seg_out;
  logic       dp_out;
  logic [3:0] an_out;
  logic       wrap_pulse;

  count_display #(.REFRESH_DIV(4), .WRAP_HOLD(6), .COMMON_ANODE(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .count_in   (count_in),
    .mode_in    (mode_in),
    .blank_lz   (blank_lz),
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .an_out     (an_out),
    .wrap_pulse (wrap_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } frame_t;

  frame_t fq[$];
  int     wq[$];
  int     dq[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc;
  logic   frame_chk = 1'b0;

  always @(posedge clk or negedge reset)
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s cyc=%0d", name, cyc);
  endtask

  // Expected codes are active-high gfedcba; pins are active-low.
  task automatic push_scan(input logic [6:0] d0, d1, d2, d3);
    fq.push_back({4'hE, ~d0, 1'b1});
    fq.push_back({4'hD, ~d1, 1'b1});
    fq.push_back({4'hB, ~d2, 1'b1});
    fq.push_back({4'h7, ~d3, 1'b1});
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
    if (cyc != n) begin
      $display("FAIL schedule wanted cyc=%0d at cyc=%0d", n, cyc);
      $fatal(1);
    end
  endtask

  task automatic chk_off(input string tag);
    chk({tag, "_an"},   an_out,     4'hF);
    chk({tag, "_seg"},  seg_out,    7'h7F);
    chk({tag, "_dp"},   dp_out,     1'b1);
    chk({tag, "_wrap"}, wrap_pulse, 1'b0);
  endtask

  initial begin : monitor
    logic [3:0] prev_an;
    int held, run;
    frame_t f;
    prev_an = 4'hF;
    held = 0;
    run = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_an = an_out;
        held = 0;
        run = 0;
      end else begin
        if (an_out != prev_an) begin
          if (frame_chk) begin
            if (prev_an != 4'hF) chk("digit_held", held, 4);
            if (fq.size() == 0) fail_now("frame_unexpected");
            else begin
              f = fq.pop_front();
              chk("frame_an",  an_out,  f.an);
              chk("frame_seg", seg_out, f.seg);
              chk("frame_dp",  dp_out,  f.dp);
            end
          end
          held = 1;
        end else begin
          held++;
        end
        prev_an = an_out;

        if (wrap_pulse) begin
          if (wq.size() == 0) fail_now("wrap_unexpected");
          else chk("wrap_cyc", cyc, wq.pop_front());
        end

        if (!dp_out) run++;
        else if (run > 0) begin
          if (dq.size() == 0) fail_now("dp_unexpected");
          else chk("dp_run", run, dq.pop_front());
          run = 0;
        end
      end
    end
  end

  initial begin
    #1 reset = 1'b0;
    #1 chk_off("rst0");
    count_in = 4'd13;
    repeat (3) @(negedge clk);
    frame_chk = 1'b1;
    push_scan(7'h3F, 7'h3F, 7'h00, 7'h3E);
    reset = 1'b1;

    wait_cyc(14);  push_scan(7'h4F, 7'h06, 7'h00, 7'h3E);
    wait_cyc(30);  push_scan(7'h4F, 7'h06, 7'h00, 7'h3E);
    wait_cyc(46);  count_in = 4'd7; blank_lz = 1'b1;
                   push_scan(7'h07, 7'h00, 7'h00, 7'h3E);
    wait_cyc(62);  blank_lz = 1'b0;
                   push_scan(7'h07, 7'h3F, 7'h00, 7'h3E);
    wait_cyc(78);  count_in = 4'd3;
                   push_scan(7'h4F, 7'h3F, 7'h00, 7'h3E);
    wait_cyc(86);  count_in = 4'd9;
    wait_cyc(94);  push_scan(7'h6F, 7'h3F, 7'h00, 7'h3E);
    wait_cyc(110); count_in = 4'd13;
                   push_scan(7'h4F, 7'h06, 7'h00, 7'h3E);
    wait_cyc(114); count_in = 4'd5;
    wait_cyc(126); push_scan(7'h6D, 7'h3F, 7'h00, 7'h3E);
    wait_cyc(142); frame_chk = 1'b0;

    // Up wrap; hold window straddles the start of digit0.
    wait_cyc(150); count_in = 4'd15;
    wait_cyc(154); count_in = 4'd0; wq.push_back(156); dq.push_back(2);
    // Back-to-back wraps: second reload keeps dp lit into the next digit0.
    wait_cyc(176); count_in = 4'd15;
    wait_cyc(183); count_in = 4'd0; wq.push_back(185);
    wait_cyc(186); count_in = 4'd15;
    wait_cyc(188); count_in = 4'd0; wq.push_back(190); dq.push_back(4);
    // Down wrap, then 15->0 while counting down must stay quiet.
    wait_cyc(200); mode_in = 1'b0;
    wait_cyc(204); count_in = 4'd15; wq.push_back(206); dq.push_back(4);
    wait_cyc(216); count_in = 4'd0;
    wait_cyc(238); frame_chk = 1'b1;
                   push_scan(7'h3F, 7'h3F, 7'h00, 7'h5E);
    wait_cyc(254); frame_chk = 1'b0;

    wait_cyc(258);
    #2 reset = 1'b0;
    #1 chk_off("rst_mid");
    repeat (2) @(negedge clk);
    count_in = 4'd4;
    mode_in = 1'b1;
    frame_chk = 1'b1;
    push_scan(7'h3F, 7'h3F, 7'h00, 7'h3E);
    reset = 1'b1;
    wait_cyc(14);  push_scan(7'h66, 7'h3F, 7'h00, 7'h3E);
    wait_cyc(30);  frame_chk = 1'b0;
    wait_cyc(34);

    chk("frames_left", fq.size(), 0);
    chk("wraps_left",  wq.size(), 0);
    chk("dp_left",     dq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
